imgproc_msg_reader: RTL and testbench
=====================================

// Module: imgproc_msg_reader
// PURPOSE
//  Avalon-MM master that drains the image processor's message FIFO in hardware instead of the CPU.
//  Polls the STATUS register (addr 0) for the word count, then reads message words from READ_MSG (addr 1).
//  Decodes 3-word "RBB" bounding-box messages and presents them as registered outputs for the rover control logic.
//  Sits between the EEE_IMGPROC slave port and the motion controller.
// PARAMETERS
//  POLL_INTERVAL  1000          cycles between STATUS polls (>=2)
//  MSG_ID         32'h00524242  word 0 of a box message ("RBB")
//  IMAGE_W        640           x coordinates must be < IMAGE_W
//  IMAGE_H        480           y coordinates must be < IMAGE_H
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  m_chipselect    out  1   slave select
//  m_read          out  1   read strobe, one-cycle pulse
//  m_write         out  1   write strobe, one-cycle pulse
//  m_address       out  3   0=STATUS, 1=READ_MSG
//  m_writedata     out  32  write data (flush only)
//  m_readdata      in   32  slave data, valid the cycle after m_read
//  enable          in   1   gates the poll timer
//  flush_req       in   1   pulse: request FIFO flush
//  bb_valid        out  1   one-cycle pulse, new box committed
//  bb_left/bb_right out 11  x_min / x_max of last box
//  bb_top/bb_bottom out 11  y_min / y_max of last box
//  bb_none         out  1   last box empty (min > max on either axis)
//  msg_count       out  16  boxes committed, wraps
//  sync_err_count  out  8   rejected words, saturates at 255
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset: all bus outputs 0; bb_* coords 0; bb_none=1; counters 0; state IDLE.
//   Poll timer loads POLL_INTERVAL-1; parse_idx=0; flush pending cleared.
//   Reset mid-access drops strobes at the next edge.
//  Bus: each read is chipselect+read+address for exactly 1 cycle.
//   The next cycle has read=0 and m_readdata is captured, so reads are always >=2 cycles apart.
//   This satisfies the slave's read-edge FIFO pop. No waitrequest.
//  FSM: IDLE, ST_RD, ST_CAP, MSG_RD, MSG_CAP, FLUSH_WR.
//  IDLE: if flush pending -> FLUSH_WR. Else, if enable, decrement the timer.
//   At 0: reload POLL_INTERVAL-1 and go to ST_RD. The timer holds while enable=0.
//  FLUSH_WR: one cycle with chipselect+write, addr 0, writedata 32'h10.
//   Clears pending and sets parse_idx=0, then -> IDLE.
//  ST_RD (addr 0) -> ST_CAP: words_left <= m_readdata[15:8].
//   If nonzero -> MSG_RD, else -> IDLE.
//  MSG_RD (addr 1) -> MSG_CAP: words_left -= 1, then parse m_readdata by parse_idx.
//   idx0: ==MSG_ID -> idx1; else sync_err++ and stay at idx0.
//   idx1: latch x=d[26:16], y=d[10:0] as the pending min -> idx2.
//   idx2: latch the pending max, commit all four coords, bb_valid=1 on the next cycle only, msg_count++ -> idx0.
//   In idx1/idx2, reject the word if d[31:27]!=0, d[15:11]!=0, x>=IMAGE_W or y>=IMAGE_H.
//    A rejected word does sync_err++ and sets idx0 with no commit.
//   After MSG_CAP: words_left!=0 -> MSG_RD, else -> IDLE.
//  parse_idx persists across polls, so messages split over polls are reassembled.
//  bb_none = (left>right)|(top>bottom), updated together with the coords.
//   An empty frame (639,479,0,0) gives bb_none=1 with bb_valid still pulsed.
//  flush_req in any state sets pending; it is serviced on the next IDLE, ahead of polling.
//   flush_req on the same cycle as the service keeps pending set.
//  enable=0 mid-drain: the current drain still completes.
//  Output coords hold their value between commits.
// TESTING
//  Status=0x0300 then words 0x00524242, 0x000A0014, 0x00640078 -> one bb_valid; L=10,T=20,R=100,B=120; bb_none=0; msg_count=1.
//  Status reports 1 word (ID), next poll 2 words -> box commits only after the second poll; sync_err_count=0.
//  Words 0xDEADBEEF, then a valid message -> sync_err_count=1; box from the valid message committed.
//  Message with coord x=700 (>=640) -> sync_err++, no bb_valid; the next valid message parses.
//  Min (639,479), max (0,0) -> bb_valid with bb_none=1.
//  flush_req during MSG_RD -> after drain a single write to addr0 of 0x10; parse_idx=0; reads spaced >=2 cycles throughout.

Source files
------------

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that polls the image processor message FIFO and decodes
// 3-word "RBB" bounding-box messages into registered outputs.
module imgproc_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter logic [31:0] MSG_ID        = 32'h00524242,
    parameter int unsigned IMAGE_W       = 640,
    parameter int unsigned IMAGE_H       = 480
) (
    input  logic        clk,
    input  logic        reset,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        enable,
    input  logic        flush_req,
    output logic        bb_valid,
    output logic [10:0] bb_left,
    output logic [10:0] bb_right,
    output logic [10:0] bb_top,
    output logic [10:0] bb_bottom,
    output logic        bb_none,
    output logic [15:0] msg_count,
    output logic [7:0]  sync_err_count,
    output logic        busy
);

    localparam int unsigned TIMER_W = $clog2(POLL_INTERVAL);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
    localparam int unsigned COORD_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        ST_RD,
        ST_CAP,
        MSG_RD,
        MSG_CAP,
        FLUSH_WR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [7:0]           words_left;
    logic [1:0]           parse_idx;
    logic                 flush_pending;
    logic [COORD_W-1:0]   min_x;
    logic [COORD_W-1:0]   min_y;

    logic [COORD_W-1:0]   rd_x;
    logic [COORD_W-1:0]   rd_y;
    logic                 coord_ok;
    logic                 word_reject;
    logic                 word_commit;

    // Field decode of the word currently on the read data bus
    always_comb begin
        rd_x        = m_readdata[26:16];
        rd_y        = m_readdata[10:0];
        coord_ok    = (m_readdata[31:27] == 5'd0) && (m_readdata[15:11] == 5'd0)
                   && (32'(rd_x) < IMAGE_W) && (32'(rd_y) < IMAGE_H);
        word_reject = 1'b0;
        word_commit = 1'b0;
        if (state == MSG_CAP) begin
            if (parse_idx == 2'd0) begin
                word_reject = (m_readdata != MSG_ID);
            end else begin
                word_reject = !coord_ok;
                word_commit = coord_ok && (parse_idx == 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush is serviced ahead of the poll timer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_pending) begin
                    state_nxt = FLUSH_WR;
                end else if (enable && (timer == '0)) begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD:    state_nxt = ST_CAP;
            ST_CAP:   state_nxt = (m_readdata[15:8] != 8'd0) ? MSG_RD : IDLE;
            MSG_RD:   state_nxt = MSG_CAP;
            MSG_CAP:  state_nxt = (words_left != 8'd0) ? MSG_RD : IDLE;
            FLUSH_WR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            m_chipselect   <= 1'b0;
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            m_address      <= 3'd0;
            m_writedata    <= 32'd0;
            busy           <= 1'b0;
            timer          <= TIMER_RELOAD;
            words_left     <= 8'd0;
            parse_idx      <= 2'd0;
            flush_pending  <= 1'b0;
            min_x          <= '0;
            min_y          <= '0;
            bb_valid       <= 1'b0;
            bb_left        <= '0;
            bb_right       <= '0;
            bb_top         <= '0;
            bb_bottom      <= '0;
            bb_none        <= 1'b1;
            msg_count      <= 16'd0;
            sync_err_count <= 8'd0;
        end else begin
            m_chipselect <= (state_nxt == ST_RD) || (state_nxt == MSG_RD) || (state_nxt == FLUSH_WR);
            m_read       <= (state_nxt == ST_RD) || (state_nxt == MSG_RD);
            m_write      <= (state_nxt == FLUSH_WR);
            m_address    <= (state_nxt == MSG_RD) ? 3'd1 : 3'd0;
            m_writedata  <= (state_nxt == FLUSH_WR) ? 32'h10 : 32'h0;
            busy         <= (state_nxt != IDLE);
            bb_valid     <= 1'b0;

            // A request arriving on the service cycle re-arms the flush
            if (flush_req) begin
                flush_pending <= 1'b1;
            end else if (state == FLUSH_WR) begin
                flush_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!flush_pending && enable) begin
                        timer <= (timer == '0) ? TIMER_RELOAD : timer - TIMER_W'(1);
                    end
                end
                ST_CAP:   words_left <= m_readdata[15:8];
                MSG_RD:   words_left <= words_left - 8'd1;
                MSG_CAP: begin
                    if (word_reject) begin
                        parse_idx <= 2'd0;
                    end else if (parse_idx == 2'd0) begin
                        parse_idx <= 2'd1;
                    end else if (parse_idx == 2'd1) begin
                        min_x     <= rd_x;
                        min_y     <= rd_y;
                        parse_idx <= 2'd2;
                    end else begin
                        parse_idx <= 2'd0;
                    end
                end
                FLUSH_WR: parse_idx <= 2'd0;
                default: ;
            endcase

            if (word_reject && (sync_err_count != 8'hFF)) begin
                sync_err_count <= sync_err_count + 8'd1;
            end

            if (word_commit) begin
                bb_left   <= min_x;
                bb_top    <= min_y;
                bb_right  <= rd_x;
                bb_bottom <= rd_y;
                bb_none   <= (min_x > rd_x) || (min_y > rd_y);
                bb_valid  <= 1'b1;
                msg_count <= msg_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Bench for imgproc_msg_reader: behavioural FIFO slave, message-level reference
// model feeding a scoreboard, and a monitor checking bus protocol and boxes.
module tb_imgproc_msg_reader;

    localparam int unsigned POLL = 8;
    localparam logic [31:0] ID   = 32'h00524242;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_chipselect, m_read, m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        enable, flush_req;
    logic        bb_valid;
    logic [10:0] bb_left, bb_right, bb_top, bb_bottom;
    logic        bb_none;
    logic [15:0] msg_count;
    logic [7:0]  sync_err_count;
    logic        busy;

    imgproc_msg_reader #(
        .POLL_INTERVAL(POLL),
        .MSG_ID(ID),
        .IMAGE_W(640),
        .IMAGE_H(480)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_chipselect(m_chipselect),
        .m_read(m_read),
        .m_write(m_write),
        .m_address(m_address),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .enable(enable),
        .flush_req(flush_req),
        .bb_valid(bb_valid),
        .bb_left(bb_left),
        .bb_right(bb_right),
        .bb_top(bb_top),
        .bb_bottom(bb_bottom),
        .bb_none(bb_none),
        .msg_count(msg_count),
        .sync_err_count(sync_err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int t;
        int r;
        int b;
        bit none;
    } box_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] fifo[$];
    box_t        exp_q[$];
    logic [31:0] held[$];
    int          exp_msgs = 0;
    int          exp_errs = 0;
    int          exp_writes = 0;
    int          writes_seen = 0;
    int          boxes_seen = 0;
    box_t        last_box;
    bit          prev_read = 1'b0;
    int          st_n;
    box_t        eb;

    // Slave: STATUS[15:8] = words available, READ_MSG pops, write 0x10 flushes
    always @(posedge clk) begin
        if (m_chipselect && m_read) begin
            if (m_address == 3'd0) begin
                st_n = fifo.size();
                if (st_n > 255) st_n = 255;
                m_readdata <= {16'h0, st_n[7:0], 8'h0};
            end else if (fifo.size() > 0) begin
                m_readdata <= fifo.pop_front();
            end else begin
                m_readdata <= 32'h0;
            end
        end
        if (m_chipselect && m_write && m_address == 3'd0 && m_writedata == 32'h10)
            fifo.delete();
    end

    function automatic bit coord_ok(input logic [31:0] w);
        return ((w & 32'hF800F800) == 32'h0) && ((w >> 16) < 640) && ((w & 32'hFFFF) < 480);
    endfunction

    // Reference model: collect words of a message, emit a box when three are held
    task automatic model_word(input logic [31:0] w);
        box_t bx;
        if (held.size() == 0) begin
            if (w == ID) held.push_back(w);
            else exp_errs++;
        end else if (!coord_ok(w)) begin
            exp_errs++;
            held.delete();
        end else begin
            held.push_back(w);
            if (held.size() == 3) begin
                bx.l = int'(held[1] >> 16);
                bx.t = int'(held[1] & 32'hFFFF);
                bx.r = int'(held[2] >> 16);
                bx.b = int'(held[2] & 32'hFFFF);
                bx.none = (bx.l > bx.r) || (bx.t > bx.b);
                exp_q.push_back(bx);
                last_box = bx;
                exp_msgs++;
                held.delete();
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        fifo.push_back(w);
        model_word(w);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drain();
        int n = 0;
        enable = 1'b1;
        while ((fifo.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=<5000 fifo=%0d", n, fifo.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: bus protocol and scoreboard comparison of committed boxes
    always @(negedge clk) begin
        if (!reset) begin
            if (m_read) begin
                checks++;
                if (prev_read || !m_chipselect || m_write) begin
                    failures++;
                    $display("FAIL read_spacing actual=prev%0d_cs%0d_wr%0d expected=prev0_cs1_wr0",
                             prev_read, m_chipselect, m_write);
                end
            end
            prev_read = m_read;
            if (m_write) begin
                writes_seen++;
                checks++;
                if (m_address != 3'd0 || m_writedata != 32'h10 || !m_chipselect || m_read) begin
                    failures++;
                    $display("FAIL flush_write actual=a%0d_d%0h_cs%0d expected=a0_d10_cs1",
                             m_address, m_writedata, m_chipselect);
                end
            end
            if (bb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bb_valid actual=1 expected=0");
                end else begin
                    eb = exp_q.pop_front();
                    boxes_seen++;
                    if (int'(bb_left) != eb.l || int'(bb_top) != eb.t || int'(bb_right) != eb.r ||
                        int'(bb_bottom) != eb.b || bb_none != eb.none || int'(msg_count) != (boxes_seen & 16'hFFFF)) begin
                        failures++;
                        $display("FAIL box actual=%0d,%0d,%0d,%0d,n%0d,c%0d expected=%0d,%0d,%0d,%0d,n%0d,c%0d",
                                 bb_left, bb_top, bb_right, bb_bottom, bb_none, msg_count,
                                 eb.l, eb.t, eb.r, eb.b, eb.none, boxes_seen);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] pend[$];
        int wait_n;
        int k;
        reset = 1'b1;
        enable = 1'b0;
        flush_req = 1'b0;
        m_readdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_bus", {27'd0, m_chipselect, m_read, m_write, m_address, m_writedata}, 64'd0);
        chk("rst_coords", {bb_left, bb_right, bb_top, bb_bottom}, 64'd0);
        chk("rst_none", bb_none, 1);
        chk("rst_counters", {msg_count, sync_err_count, bb_valid, busy}, 0);

        // Timer must hold while disabled
        send_word(ID); send_word(32'h000A0014); send_word(32'h00640078);
        repeat (4 * POLL) @(negedge clk);
        chk("enable_hold_fifo", fifo.size(), 3);
        chk("enable_hold_busy", busy, 0);
        drain();
        chk("basic_coords", {bb_left, bb_top, bb_right, bb_bottom}, {11'd10, 11'd20, 11'd100, 11'd120});
        chk("basic_none", bb_none, 0);
        chk("basic_count", msg_count, 1);

        // Message split over two polls
        send_word(ID);
        drain();
        chk("split_no_commit", msg_count, 1);
        send_word(32'h00050006); send_word(32'h00070008);
        drain();
        chk("split_commit", msg_count, 2);
        chk("split_no_err", sync_err_count, 0);

        send_word(32'hDEADBEEF);
        send_word(ID); send_word(32'h00010002); send_word(32'h00030004);
        drain();
        chk("garbage_err", sync_err_count, 1);
        chk("garbage_count", msg_count, 3);

        // x = 700 out of range
        send_word(ID); send_word(32'h02BC0010);
        send_word(ID); send_word(32'h00200030); send_word(32'h00400050);
        drain();
        chk("range_err", sync_err_count, 2);
        chk("range_count", msg_count, 4);

        // Empty frame
        send_word(ID); send_word(32'h027F01DF); send_word(32'h00000000);
        drain();
        chk("empty_none", bb_none, 1);
        chk("empty_coords", {bb_left, bb_top, bb_right, bb_bottom}, {11'd639, 11'd479, 11'd0, 11'd0});

        // Flush requested mid-drain leaves parser at word 0
        send_word(ID); send_word(32'h000A0014);
        wait_n = 0;
        while (!(m_read && m_address == 3'd1) && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n >= 200) begin
            checks++;
            failures++;
            $display("FAIL flush_msg_rd_timeout actual=%0d expected=<200", wait_n);
        end
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        held.delete();
        exp_writes++;
        drain();
        repeat (6) @(negedge clk);
        chk("flush_writes", writes_seen, exp_writes);
        send_word(32'h00640078);
        send_word(ID); send_word(32'h00100010); send_word(32'h00200020);
        drain();
        chk("flush_parse_err", sync_err_count, 3);
        chk("flush_parse_count", msg_count, 6);

        // Randomized traffic with random batch boundaries and enable gaps
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    pend.push_back(ID);
                    pend.push_back({5'd0, 11'($urandom_range(0, 639)), 5'd0, 11'($urandom_range(0, 479))});
                    pend.push_back({5'd0, 11'($urandom_range(0, 639)), 5'd0, 11'($urandom_range(0, 479))});
                end
                2: pend.push_back($urandom());
                default: begin
                    pend.push_back(ID);
                    if ($urandom_range(0, 1) == 0)
                        pend.push_back({5'd0, 11'($urandom_range(640, 2047)), 5'd0, 11'($urandom_range(0, 479))});
                    else
                        pend.push_back({5'd0, 11'($urandom_range(0, 639)), 5'd0, 11'($urandom_range(480, 2047))});
                    pend.push_back({5'd0, 11'($urandom_range(0, 639)), 5'd0, 11'($urandom_range(0, 479))});
                end
            endcase
            while (pend.size() > 0) begin
                k = $urandom_range(1, 4);
                for (int j = 0; j < k && pend.size() > 0; j++) send_word(pend.pop_front());
                enable = ($urandom_range(0, 3) != 0);
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
        end
        drain();
        chk("rand_count", msg_count, 16'(exp_msgs));
        chk("rand_errs", sync_err_count, (exp_errs > 255) ? 255 : exp_errs);

        // Saturation of the error counter
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 140; j++) send_word($urandom() | 32'h80000000);
            drain();
        end
        chk("sat_errs", sync_err_count, 8'hFF);
        chk("final_count", msg_count, 16'(exp_msgs));
        chk("final_hold", {bb_left, bb_top, bb_right, bb_bottom, 9'd0, bb_none},
            {11'(last_box.l), 11'(last_box.t), 11'(last_box.r), 11'(last_box.b), 9'd0, last_box.none});
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_writes", writes_seen, exp_writes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
